// File: rtl/apb_master_sched_pkg.sv
// rtl/apb_master_sched_pkg.sv - shared FSM encodings and defaults for the APB master scheduler
package apb_master_sched_pkg;

    typedef enum logic [1:0] {
        SCHED_IDLE   = 2'd0,
        SCHED_SETUP  = 2'd1,
        SCHED_ACCESS = 2'd2
    } sched_state_e;

    // ACCESS cycles allowed before a stuck slave is turned into an error response
    localparam int SCHED_DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/apb_rr_pick.sv
// rtl/apb_rr_pick.sv - combinational round-robin picker starting after the last grant
//
// Ports:
//   reqs_i      request vector, one bit per port
//   last_idx_i  index granted most recently
//   next_idx_o  first requester at last_idx_i+1, +2, ... modulo PORTS
//   valid_o     at least one request present
module apb_rr_pick #(
    parameter int PORTS = 4,
    parameter int IW    = 2
) (
    input  logic [PORTS-1:0] reqs_i,
    input  logic [IW-1:0]    last_idx_i,
    output logic [IW-1:0]    next_idx_o,
    output logic             valid_o
);

    int best_dist;

    // Each requester's distance past last_idx_i; the smallest distance wins.
    // The last granted port has distance PORTS-1, so it is served last.
    always_comb begin
        next_idx_o = last_idx_i;
        valid_o    = 1'b0;
        best_dist  = PORTS;
        for (int i = 0; i < PORTS; i++) begin
            if (reqs_i[i] && (((i + PORTS - 1 - int'(last_idx_i)) % PORTS) < best_dist)) begin
                best_dist  = (i + PORTS - 1 - int'(last_idx_i)) % PORTS;
                next_idx_o = IW'(i);
                valid_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_master_sched.sv
// rtl/apb_master_sched.sv - round-robin sharing of one downstream APB master port
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   S_PADDR/S_PWRITE/S_PSELx/S_PWDATA   per-core request side (flattened, core 0 in LSBs)
//   S_PRDATA/S_PREADY/S_PSLVERR         per-core completion, only the granted core is driven
//   M_PADDR/M_PWRITE/M_PSEL/M_PENABLE/M_PWDATA  downstream APB master outputs
//   M_PRDATA/M_PREADY           downstream response
//   grant_idx                   current / most recent granted core
module apb_master_sched
    import apb_master_sched_pkg::*;
#(
    parameter int MASTER_PORTS = 4,
    parameter int BUS_WIDTH    = 16,
    parameter int DATA_WIDTH   = 16,
    parameter int TIMEOUT      = SCHED_DEFAULT_TIMEOUT,
    localparam int GW          = (MASTER_PORTS > 1) ? $clog2(MASTER_PORTS) : 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [MASTER_PORTS*BUS_WIDTH-1:0]  S_PADDR,
    input  logic [MASTER_PORTS-1:0]            S_PWRITE,
    input  logic [MASTER_PORTS-1:0]            S_PSELx,
    input  logic [MASTER_PORTS*DATA_WIDTH-1:0] S_PWDATA,
    output logic [MASTER_PORTS*DATA_WIDTH-1:0] S_PRDATA,
    output logic [MASTER_PORTS-1:0]            S_PREADY,
    output logic [MASTER_PORTS-1:0]            S_PSLVERR,
    output logic [BUS_WIDTH-1:0]               M_PADDR,
    output logic                               M_PWRITE,
    output logic                               M_PSEL,
    output logic                               M_PENABLE,
    output logic [DATA_WIDTH-1:0]              M_PWDATA,
    input  logic [DATA_WIDTH-1:0]              M_PRDATA,
    input  logic                               M_PREADY,
    output logic [GW-1:0]                      grant_idx
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    sched_state_e          state_q, state_d;
    logic [GW-1:0]         grant_q, grant_d;
    logic [BUS_WIDTH-1:0]  paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  pwrite_q, pwrite_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    logic [GW-1:0]         pick_idx;
    logic                  pick_valid;
    logic                  xfer_ok;
    logic                  xfer_timeout;

    apb_rr_pick #(
        .PORTS (MASTER_PORTS),
        .IW    (GW)
    ) u_pick (
        .reqs_i     (S_PSELx),
        .last_idx_i (grant_q),
        .next_idx_o (pick_idx),
        .valid_o    (pick_valid)
    );

    // A ready slave always wins over a timeout landing in the same cycle.
    assign xfer_ok      = (state_q == SCHED_ACCESS) && M_PREADY;
    assign xfer_timeout = (state_q == SCHED_ACCESS) && !M_PREADY &&
                          (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pwrite_d = pwrite_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            SCHED_IDLE: begin
                if (pick_valid) begin
                    state_d = SCHED_SETUP;
                    grant_d = pick_idx;
                    for (int i = 0; i < MASTER_PORTS; i++) begin
                        if (pick_idx == GW'(i)) begin
                            paddr_d  = S_PADDR[i*BUS_WIDTH +: BUS_WIDTH];
                            pwdata_d = S_PWDATA[i*DATA_WIDTH +: DATA_WIDTH];
                            pwrite_d = S_PWRITE[i];
                        end
                    end
                end
            end
            SCHED_SETUP: state_d = SCHED_ACCESS;
            SCHED_ACCESS: begin
                if (xfer_ok || xfer_timeout) begin
                    state_d = SCHED_IDLE;
                    cnt_d   = '0;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = SCHED_IDLE;
        endcase
        // PSEL/PENABLE are derived from the next state so they leave flops cleanly
        psel_d    = (state_d != SCHED_IDLE);
        penable_d = (state_d == SCHED_ACCESS);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= SCHED_IDLE;
            grant_q   <= GW'(MASTER_PORTS - 1);
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pwrite_q  <= pwrite_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        S_PREADY  = '0;
        S_PSLVERR = '0;
        S_PRDATA  = '0;
        for (int i = 0; i < MASTER_PORTS; i++) begin
            if (grant_q == GW'(i)) begin
                S_PREADY[i]  = xfer_ok || xfer_timeout;
                S_PSLVERR[i] = xfer_timeout;
                if (xfer_ok) begin
                    S_PRDATA[i*DATA_WIDTH +: DATA_WIDTH] = M_PRDATA;
                end
            end
        end
    end

    assign M_PADDR   = paddr_q;
    assign M_PWDATA  = pwdata_q;
    assign M_PWRITE  = pwrite_q;
    assign M_PSEL    = psel_q;
    assign M_PENABLE = penable_q;
    assign grant_idx = grant_q;

endmodule

// File: tb/tb_apb_master_sched.sv
// tb/tb_apb_master_sched.sv - scoreboard bench for apb_master_sched
module tb_apb_master_sched;

    localparam int MP = 4;
    localparam int BW = 16;
    localparam int DW = 16;
    localparam int TO = 8;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [MP*BW-1:0] s_paddr;
    logic [MP-1:0]  s_pwrite;
    logic [MP-1:0]  s_psel;
    logic [MP*DW-1:0] s_pwdata;
    logic [MP*DW-1:0] s_prdata;
    logic [MP-1:0]  s_pready;
    logic [MP-1:0]  s_pslverr;
    logic [BW-1:0]  m_paddr;
    logic           m_pwrite;
    logic           m_psel;
    logic           m_penable;
    logic [DW-1:0]  m_pwdata;
    logic [DW-1:0]  m_prdata;
    logic [DW-1:0]  m_prdata_drv;
    logic           m_pready;
    logic [1:0]     grant_idx;
    logic           rd_from_addr;

    always #5 clk = ~clk;

    // Slave model: either a fixed value or address + 0x1000
    assign m_prdata = rd_from_addr ? (m_paddr + 16'h1000) : m_prdata_drv;

    apb_master_sched #(
        .MASTER_PORTS (MP),
        .BUS_WIDTH    (BW),
        .DATA_WIDTH   (DW),
        .TIMEOUT      (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .S_PADDR   (s_paddr),
        .S_PWRITE  (s_pwrite),
        .S_PSELx   (s_psel),
        .S_PWDATA  (s_pwdata),
        .S_PRDATA  (s_prdata),
        .S_PREADY  (s_pready),
        .S_PSLVERR (s_pslverr),
        .M_PADDR   (m_paddr),
        .M_PWRITE  (m_pwrite),
        .M_PSEL    (m_psel),
        .M_PENABLE (m_penable),
        .M_PWDATA  (m_pwdata),
        .M_PRDATA  (m_prdata),
        .M_PREADY  (m_pready),
        .grant_idx (grant_idx)
    );

    typedef struct {
        int          idx;
        logic        err;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    logic [MP*DW-1:0] ev;
    int n_cmp = 0;
    int n_bad = 0;
    int c;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Monitor: every completion pulse must match the head of the scoreboard
    always @(negedge clk) begin
        if (reset && (s_pready != '0)) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pready: got 0x%0h expected no completion", s_pready);
            end else begin
                e  = sb.pop_front();
                ev = '0;
                ev[e.idx*DW +: DW] = e.data;
                check("done_port", 64'(s_pready), 64'(4'b0001 << e.idx));
                check("done_err", 64'(s_pslverr), e.err ? 64'(4'b0001 << e.idx) : 64'd0);
                check("done_data", s_prdata, ev);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        s_psel       = '0;
        s_pwrite     = '0;
        s_paddr      = '0;
        s_pwdata     = '0;
        m_pready     = 1'b0;
        m_prdata_drv = '0;
        rd_from_addr = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    // Count negedges up to and including the one showing a completion
    task automatic wait_done(input string name, input int budget, output int cyc);
        cyc = 0;
        while (cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (s_pready != '0) return;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got no S_PREADY expected one within %0d cycles", name, budget);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        do_reset();

        // Reset state
        @(negedge clk);
        check("rst_psel", 64'(m_psel), 64'd0);
        check("rst_penable", 64'(m_penable), 64'd0);
        check("rst_paddr", 64'(m_paddr), 64'd0);
        check("rst_pwdata", 64'(m_pwdata), 64'd0);
        check("rst_pwrite", 64'(m_pwrite), 64'd0);
        check("rst_pready", 64'(s_pready), 64'd0);
        check("rst_pslverr", 64'(s_pslverr), 64'd0);
        check("rst_prdata", s_prdata, 64'd0);
        check("rst_grant", 64'(grant_idx), 64'd3);

        // Single zero-wait read from core 1
        step();
        s_psel[1] = 1'b1;
        s_paddr[1*BW +: BW] = 16'h0040;
        m_pready = 1'b1;
        m_prdata_drv = 16'hBEEF;
        sb.push_back('{1, 1'b0, 16'hBEEF});
        @(negedge clk);
        check("t1_c0_psel", 64'(m_psel), 64'd0);
        step();
        @(negedge clk);
        check("t1_c1_psel", 64'(m_psel), 64'd1);
        check("t1_c1_penable", 64'(m_penable), 64'd0);
        check("t1_c1_paddr", 64'(m_paddr), 64'h0040);
        check("t1_c1_grant", 64'(grant_idx), 64'd1);
        step();
        @(negedge clk);
        check("t1_c2_penable", 64'(m_penable), 64'd1);
        check("t1_c2_pready", 64'(s_pready), 64'b0010);
        step();
        s_psel = '0;

        // Round-robin with all cores requesting continuously
        do_reset();
        for (int i = 0; i < MP; i++) s_paddr[i*BW +: BW] = BW'(i * 256);
        s_psel = 4'hF;
        rd_from_addr = 1'b1;
        m_pready = 1'b1;
        sb.push_back('{0, 1'b0, 16'h1000});
        sb.push_back('{1, 1'b0, 16'h1100});
        sb.push_back('{2, 1'b0, 16'h1200});
        sb.push_back('{3, 1'b0, 16'h1300});
        sb.push_back('{0, 1'b0, 16'h1000});
        for (int k = 0; k < 5; k++) begin
            wait_done("t2_done", 10, c);
            check("t2_period", 64'(c), 64'd3);
        end
        step();
        s_psel = '0;
        rd_from_addr = 1'b0;

        // Write with five wait states; request changes after latching are ignored
        m_pready = 1'b0;
        m_prdata_drv = 16'h7777;
        s_psel[2] = 1'b1;
        s_pwrite[2] = 1'b1;
        s_paddr[2*BW +: BW] = 16'h0022;
        s_pwdata[2*DW +: DW] = 16'h1234;
        sb.push_back('{2, 1'b0, 16'h7777});
        step();
        s_psel[2] = 1'b0;
        s_pwdata[2*DW +: DW] = 16'hFFFF;
        s_paddr[2*BW +: BW] = 16'hFFFF;
        @(negedge clk);
        check("t3_setup_psel", 64'(m_psel), 64'd1);
        check("t3_setup_penable", 64'(m_penable), 64'd0);
        check("t3_setup_pwdata", 64'(m_pwdata), 64'h1234);
        check("t3_setup_pwrite", 64'(m_pwrite), 64'd1);
        for (int k = 1; k <= 6; k++) begin
            step();
            m_pready = (k == 6);
            @(negedge clk);
            check("t3_penable", 64'(m_penable), 64'd1);
            check("t3_pwdata", 64'(m_pwdata), 64'h1234);
            check("t3_paddr", 64'(m_paddr), 64'h0022);
            check("t3_pready", 64'(s_pready), (k == 6) ? 64'b0100 : 64'd0);
        end
        step();
        m_pready = 1'b0;
        s_pwrite = '0;
        @(negedge clk);
        check("t3_idle_psel", 64'(m_psel), 64'd0);

        // Timeout: slave never ready
        step();
        s_psel[3] = 1'b1;
        s_paddr[3*BW +: BW] = 16'h0300;
        m_prdata_drv = 16'hDEAD;
        sb.push_back('{3, 1'b1, 16'h0000});
        wait_done("t4_timeout", 20, c);
        check("t4_latency", 64'(c), 64'd10);
        step();
        s_psel = '0;
        s_psel[0] = 1'b1;
        s_paddr[0*BW +: BW] = 16'h0004;
        m_pready = 1'b1;
        m_prdata_drv = 16'h0A0A;
        sb.push_back('{0, 1'b0, 16'h0A0A});
        wait_done("t4_after", 10, c);
        check("t4_after_latency", 64'(c), 64'd3);
        step();
        s_psel = '0;
        m_pready = 1'b0;

        // PREADY on the exact timeout cycle wins
        s_psel[1] = 1'b1;
        s_paddr[1*BW +: BW] = 16'h0110;
        m_prdata_drv = 16'hC0DE;
        sb.push_back('{1, 1'b0, 16'hC0DE});
        step();
        step();
        for (int k = 1; k <= 8; k++) begin
            m_pready = (k == 8);
            @(negedge clk);
            check("t5_pready", 64'(s_pready), (k == 8) ? 64'b0010 : 64'd0);
            check("t5_pslverr", 64'(s_pslverr), 64'd0);
            step();
        end
        s_psel = '0;
        m_pready = 1'b0;

        // Asynchronous reset in the middle of ACCESS
        s_psel[2] = 1'b1;
        s_paddr[2*BW +: BW] = 16'h0222;
        step();
        step();
        @(negedge clk);
        check("t6_pre_penable", 64'(m_penable), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check("t6_psel", 64'(m_psel), 64'd0);
        check("t6_penable", 64'(m_penable), 64'd0);
        check("t6_pready", 64'(s_pready), 64'd0);
        check("t6_grant", 64'(grant_idx), 64'd3);
        s_psel = '0;
        step();
        step();
        reset = 1'b1;
        s_paddr[0*BW +: BW] = 16'h0000;
        s_paddr[3*BW +: BW] = 16'h0333;
        s_psel = 4'b1001;
        rd_from_addr = 1'b1;
        m_pready = 1'b1;
        sb.push_back('{0, 1'b0, 16'h1000});
        sb.push_back('{3, 1'b0, 16'h1333});
        wait_done("t6_first", 10, c);
        check("t6_first_latency", 64'(c), 64'd3);
        step();
        s_psel[0] = 1'b0;
        wait_done("t6_second", 10, c);
        check("t6_second_latency", 64'(c), 64'd3);
        step();
        s_psel = '0;
        m_pready = 1'b0;
        rd_from_addr = 1'b0;
        step();
        step();
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/apb_master_sched.md
Name: apb_master_sched

Overview:
- Shares one downstream APB master port between MASTER_PORTS core-side requesters.
- Round-robin grant; holds the grant for exactly one complete APB transfer (SETUP, then ACCESS).
- Sequences PSEL/PENABLE and returns PREADY/PRDATA to the granted core.
- Sits between the core APB master ports and the slave-side address decoder/intercon; a hang timeout converts a stuck slave into an error response.

Parameters:
- MASTER_PORTS, 4, number of requesting cores (>=1).
- BUS_WIDTH, 16, PADDR width.
- DATA_WIDTH, 16, PWDATA/PRDATA width.
- TIMEOUT, 255, maximum ACCESS cycles before abort. 0 disables the timeout.

Ports:
- clk  in  1  clock, all state on posedge.
- reset  in  1  asynchronous, active-low reset.
- S_PADDR  in  MASTER_PORTS*BUS_WIDTH  per-core address.
- S_PWRITE  in  MASTER_PORTS  per-core write flag.
- S_PSELx  in  MASTER_PORTS  per-core request (PSEL).
- S_PWDATA  in  MASTER_PORTS*DATA_WIDTH  per-core write data.
- S_PRDATA  out  MASTER_PORTS*DATA_WIDTH  read data; only the granted slice is driven, others are 0.
- S_PREADY  out  MASTER_PORTS  one-cycle completion to the granted core.
- S_PSLVERR  out  MASTER_PORTS  one-cycle error (timeout) to the granted core.
- M_PADDR  out  BUS_WIDTH  latched address to the decoder.
- M_PWRITE  out  1  latched write flag.
- M_PSEL  out  1  downstream select.
- M_PENABLE  out  1  downstream enable.
- M_PWDATA  out  DATA_WIDTH  latched write data.
- M_PRDATA  in  DATA_WIDTH  downstream read data.
- M_PREADY  in  1  downstream ready.
- grant_idx  out  clog2(MASTER_PORTS), min 1  current/last granted core.

Behaviour:
- Reset (reset=0, async): state=IDLE.
  - M_PSEL=0, M_PENABLE=0.
  - M_PADDR/M_PWDATA/M_PWRITE=0.
  - S_PREADY/S_PSLVERR/S_PRDATA=0.
  - grant_idx=MASTER_PORTS-1, so core 0 wins first. Timeout counter=0.
  - Reset mid-transfer aborts silently; no PREADY is issued.
- FSM states: IDLE -> SETUP -> ACCESS -> IDLE.
- IDLE:
  - If |S_PSELx, select the first requester scanning grant_idx+1, grant_idx+2, ... modulo MASTER_PORTS.
  - Register grant_idx and latch that core's PADDR/PWRITE/PWDATA. Go to SETUP. Otherwise stay in IDLE.
- SETUP: M_PSEL=1, M_PENABLE=0 for exactly one cycle; then go to ACCESS.
- ACCESS: M_PSEL=1, M_PENABLE=1. Counter increments each cycle M_PREADY=0.
  - M_PREADY=1:
    - S_PREADY[grant_idx]=1 combinationally in that cycle.
    - S_PRDATA slice = M_PRDATA.
    - Next state IDLE; counter cleared.
  - TIMEOUT!=0 and counter==TIMEOUT-1 with M_PREADY=0:
    - S_PREADY[grant_idx]=1 and S_PSLVERR[grant_idx]=1 that cycle; PRDATA slice=0.
    - Next state IDLE.
  - M_PREADY and timeout in the same cycle: M_PREADY wins, no error.
- Throughput and latency:
  - A transfer occupies 3 cycles minimum (IDLE decision, SETUP, ACCESS).
  - Request seen in cycle 0 gives S_PREADY in cycle 2 with a zero-wait slave.
- Latched request: changes to S_PADDR/S_PWDATA or deassertion of S_PSELx by the granted core after IDLE are ignored; the latched transfer completes.
- Requirement on cores: a core must drop PSEL the cycle after S_PREADY. A core still requesting is eligible again only after the other requesters, per round-robin.
- Fairness: with all cores requesting continuously, grants rotate 0,1,2,3,0...; no core waits more than MASTER_PORTS-1 transfers.
- MASTER_PORTS=1: grant_idx is always 0; FSM behaviour is unchanged.
- M_PSEL/M_PENABLE are registered outputs (glitch-free); S_PREADY/S_PRDATA are combinational from M_PREADY/M_PRDATA.

Decomposition:
- Shared package/include (vmicro16_soc_config.v style defines):
  - State encodings SCHED_IDLE=2'd0, SCHED_SETUP=2'd1, SCHED_ACCESS=2'd2.
  - Default timeout constant.
- Sub-module apb_rr_pick (combinational):
  - Inputs: reqs[MASTER_PORTS], last grant index.
  - Outputs: next index and a valid flag.
  - Instanced once; reusable by the cluster-level arbiter.

Test Plan:
- Single read, zero-wait: core1 PSEL, PADDR=0x0040, slave PREADY immediately, PRDATA=0xBEEF -> M_PSEL at cycle 1, M_PENABLE at cycle 2, S_PREADY[1]=1 and S_PRDATA[1]=0xBEEF at cycle 2, grant_idx=1.
- Round-robin: all 4 cores request continuously with 0-wait slave -> completion order 0,1,2,3,0, one transfer per 3 cycles.
- Wait states: slave holds PREADY low 5 cycles on write PWDATA=0x1234 -> M_PWDATA stable at 0x1234 and PENABLE high for 6 ACCESS cycles, single S_PREADY pulse.
- Timeout: TIMEOUT=8, slave never ready -> S_PREADY[g]=S_PSLVERR[g]=1 in 8th ACCESS cycle, PRDATA=0, next request served normally.
- Timeout race: PREADY arrives on the exact timeout cycle -> S_PSLVERR=0, data returned.
- Async reset mid-ACCESS: drop reset with no clock edge -> M_PSEL/M_PENABLE=0 immediately, no S_PREADY, core 0 granted first after release.
